vertex_feeder: RTL and testbench
================================

# vertex_feeder

Fetches a model's vertices from a vertex memory and streams them, together with the model's MVP matrix, into the transform pipeline's input interface (MVP load, then `i_vertex`/`i_vertex_dv`/`i_vertex_last`, throttled by the pipeline's `ready`). It is the transmitter for that interface and sits between the model/scene controller and the transform pipeline. One `i_start` pulse produces one complete draw: one MVP transfer, N vertex transfers with `last` on the final one, then a `o_done` pulse.

## Interface
- `DATAWIDTH`, 24: width of each signed fixed-point coordinate and matrix element.
- `ADDR_WIDTH`, 12: vertex memory address width; also the width of the vertex count.
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `i_start`  in  1  single-cycle draw request; honoured only in IDLE.
- `i_base_addr`  in  ADDR_WIDTH  address of the first vertex; sampled on accepted start.
- `i_vertex_count`  in  ADDR_WIDTH  number of vertices N; sampled on accepted start.
- `i_mvp_matrix[4][4]`  in  signed DATAWIDTH  MVP matrix; sampled on accepted start.
- `o_mem_en`  out  1  vertex memory read enable.
- `o_mem_addr`  out  ADDR_WIDTH  vertex memory read address.
- `i_mem_data`  in  3*DATAWIDTH  read data, valid the cycle after `o_mem_en`; packed {x, y, z}, x in the MSBs.
- `o_mvp_matrix[4][4]`  out  signed DATAWIDTH  latched MVP matrix.
- `o_mvp_dv`  out  1  MVP transfer strobe.
- `o_vertex[3]`  out  signed DATAWIDTH  vertex {x, y, z}; `[0]` = x.
- `o_vertex_dv`  out  1  vertex valid.
- `o_vertex_last`  out  1  qualifies the final vertex of the draw.
- `i_ready`  in  1  pipeline ready (vertex shader ready and FIFO not full).
- `o_busy`  out  1  high in every state except IDLE.
- `o_done`  out  1  one-cycle pulse at the end of a draw.

## Operation
- States: IDLE, MVP, FETCH, LATCH, PRESENT, DONE.
- IDLE: if `i_start`, latch base, count and matrix, and clear the index to 0. Go to DONE if count = 0, otherwise go to MVP. `i_start` in any other state is ignored.
- MVP: `o_mvp_dv` = `i_ready` (combinational). The state is left on the first cycle with `i_ready`=1, going to FETCH. `o_mvp_dv` is therefore high for exactly one cycle per draw.
- FETCH: `o_mem_en`=1 and `o_mem_addr` = `base + index`, truncated to ADDR_WIDTH so it wraps modulo 2^ADDR_WIDTH. Go to LATCH.
- LATCH: capture `i_mem_data` into the `o_vertex` registers. Set `o_vertex_last` = (index == count-1). Go to PRESENT.
- PRESENT: `o_vertex_dv`=1. A transfer occurs on a cycle with `o_vertex_dv` && `i_ready`.
  - On transfer with `last`=0: index+1, go to FETCH.
  - On transfer with `last`=1: go to DONE.
  - While `i_ready`=0: `o_vertex`, `o_vertex_last` and `o_vertex_dv` hold, and no memory read is issued.
- DONE: `o_done`=1 for one cycle, then IDLE.
- Outputs outside their qualifying states: `o_mem_en`=0 and `o_mvp_dv`=0. `o_vertex_dv` and `o_vertex_last` are 0 outside PRESENT. `o_vertex` and `o_mvp_matrix` keep their last values.
- Reset (including mid-draw): state goes to IDLE and the index to 0. Every output is 0 on the cycle after `rst` is sampled, including `o_vertex`, `o_mvp_matrix` and `o_mem_addr`. The draw is abandoned and `o_done` is not pulsed.

## Timing
- `i_start` sampled at edge 0:
  - cycle 1: MVP, `o_busy`=1;
  - with `i_ready`=1, first FETCH in cycle 2, LATCH in cycle 3, first `o_vertex_dv` in cycle 4.
- Steady state with `i_ready` always 1: 3 cycles per vertex (FETCH, LATCH, PRESENT).
- Draw length with no stalls: 2 + 3N cycles from start to `o_done`. `o_done` is in the cycle after the last transfer.
- Each stall cycle in MVP or PRESENT adds exactly one cycle.
- `o_busy` rises the cycle after the accepted start and falls the cycle after `o_done`.

## Test plan
- Reset: assert `rst` for 2 cycles with random inputs -> every output 0 and `o_busy`=0.
- Basic draw: base=0x010, N=3, `i_ready`=1, memory returns word=address.
  - `o_mvp_dv` in cycle 1.
  - Reads at 0x010, 0x011, 0x012.
  - `o_vertex_dv` in cycles 4, 7, 10; `last` only in cycle 10.
  - `o_done` in cycle 11.
- Backpressure: N=2, `i_ready`=0 for 5 cycles starting in the first PRESENT -> `o_vertex` stable, `o_mem_en`=0 throughout the stall, the vertex is transferred once, and `o_done` is 5 cycles later than in the no-stall case.
- Empty draw: N=0 -> no `o_mvp_dv`, no `o_mem_en`, `o_done` in cycle 1, back in IDLE in cycle 2.
- Wrap: ADDR_WIDTH=12, base=0xFFE, N=4 -> read addresses 0xFFE, 0xFFF, 0x000, 0x001.
- Control edge cases:
  - `i_start` repeated while busy -> ignored, exactly one `o_done` pulse.
  - `rst` asserted during the second PRESENT of N=4 -> outputs 0 on the next cycle, no `o_done`.
  - A fresh start after reset runs a full draw correctly.

Source files
------------

// File: rtl/vertex_feeder.sv
// Vertex feeder: reads a model's vertices from vertex memory and streams them,
// preceded by the model's MVP matrix, into the transform pipeline input.
module vertex_feeder #(
  parameter int DATAWIDTH  = 24,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_start,
  input  logic [ADDR_WIDTH-1:0]       i_base_addr,
  input  logic [ADDR_WIDTH-1:0]       i_vertex_count,
  input  logic signed [DATAWIDTH-1:0] i_mvp_matrix [4][4],
  output logic                        o_mem_en,
  output logic [ADDR_WIDTH-1:0]       o_mem_addr,
  input  logic [3*DATAWIDTH-1:0]      i_mem_data,
  output logic signed [DATAWIDTH-1:0] o_mvp_matrix [4][4],
  output logic                        o_mvp_dv,
  output logic signed [DATAWIDTH-1:0] o_vertex [3],
  output logic                        o_vertex_dv,
  output logic                        o_vertex_last,
  input  logic                        i_ready,
  output logic                        o_busy,
  output logic                        o_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_MVP, S_FETCH, S_LATCH, S_PRESENT, S_DONE
  } state_e;

  state_e                      state_q, state_d;
  logic [ADDR_WIDTH-1:0]       base_q, count_q;
  logic [ADDR_WIDTH-1:0]       index_q, index_d;
  logic                        last_q, last_d;
  logic signed [DATAWIDTH-1:0] mvp_q [4][4];
  logic signed [DATAWIDTH-1:0] vertex_q [3];

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d = state_q;
    index_d = index_q;
    last_d  = last_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          index_d = '0;
          state_d = (i_vertex_count == '0) ? S_DONE : S_MVP;
        end
      end
      S_MVP: begin
        if (i_ready) state_d = S_FETCH;
      end
      S_FETCH: state_d = S_LATCH;
      S_LATCH: begin
        last_d  = (index_q == count_q - ADDR_WIDTH'(1));
        state_d = S_PRESENT;
      end
      S_PRESENT: begin
        if (i_ready) begin
          if (last_q) begin
            state_d = S_DONE;
          end else begin
            index_d = index_q + ADDR_WIDTH'(1);
            state_d = S_FETCH;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      count_q <= '0;
      index_q <= '0;
      last_q  <= 1'b0;
      // NOTE: matrix and vertex registers are reset too, because their outputs must read 0 after reset.
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c < 4; c++) mvp_q[r][c] <= '0;
      end
      for (int k = 0; k < 3; k++) vertex_q[k] <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      last_q  <= last_d;
      if (state_q == S_IDLE && i_start) begin
        base_q  <= i_base_addr;
        count_q <= i_vertex_count;
        for (int r = 0; r < 4; r++) begin
          for (int c = 0; c < 4; c++) mvp_q[r][c] <= i_mvp_matrix[r][c];
        end
      end
      if (state_q == S_LATCH) begin
        vertex_q[0] <= i_mem_data[3*DATAWIDTH-1 -: DATAWIDTH];
        vertex_q[1] <= i_mem_data[2*DATAWIDTH-1 -: DATAWIDTH];
        vertex_q[2] <= i_mem_data[DATAWIDTH-1:0];
      end
    end
  end

  // Address wraps naturally modulo 2^ADDR_WIDTH.
  assign o_mem_addr    = base_q + index_q;
  assign o_mem_en      = (state_q == S_FETCH);
  assign o_mvp_dv      = (state_q == S_MVP) && i_ready;
  assign o_vertex_dv   = (state_q == S_PRESENT);
  assign o_vertex_last = (state_q == S_PRESENT) && last_q;
  assign o_busy        = (state_q != S_IDLE);
  assign o_done        = (state_q == S_DONE);
  assign o_mvp_matrix  = mvp_q;
  assign o_vertex      = vertex_q;

endmodule

// File: tb/tb_vertex_feeder.sv
// Directed scoreboard bench for vertex_feeder: expected reads and vertices are
// queued at start and consumed by a negedge monitor as the DUT produces them.
module tb_vertex_feeder;
  localparam int DW = 24;
  localparam int AW = 12;

  typedef logic [383:0] w_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 i_start;
  logic [AW-1:0]        i_base_addr;
  logic [AW-1:0]        i_vertex_count;
  logic signed [DW-1:0] i_mvp_matrix [4][4];
  logic                 o_mem_en;
  logic [AW-1:0]        o_mem_addr;
  logic [3*DW-1:0]      i_mem_data = '0;
  logic signed [DW-1:0] o_mvp_matrix [4][4];
  logic                 o_mvp_dv;
  logic signed [DW-1:0] o_vertex [3];
  logic                 o_vertex_dv;
  logic                 o_vertex_last;
  logic                 i_ready;
  logic                 o_busy;
  logic                 o_done;

  vertex_feeder #(.DATAWIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_start        (i_start),
    .i_base_addr    (i_base_addr),
    .i_vertex_count (i_vertex_count),
    .i_mvp_matrix   (i_mvp_matrix),
    .o_mem_en       (o_mem_en),
    .o_mem_addr     (o_mem_addr),
    .i_mem_data     (i_mem_data),
    .o_mvp_matrix   (o_mvp_matrix),
    .o_mvp_dv       (o_mvp_dv),
    .o_vertex       (o_vertex),
    .o_vertex_dv    (o_vertex_dv),
    .o_vertex_last  (o_vertex_last),
    .i_ready        (i_ready),
    .o_busy         (o_busy),
    .o_done         (o_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;
  int d0, m0, r0, x0;
  int done_cnt = 0, mvp_cnt = 0, mem_cnt = 0;
  int done_rel = 0, mvp_rel = 0, rel_m;
  int xfer_rel [$];
  logic [AW-1:0]     exp_addr_q [$];
  logic [3*DW:0]     exp_v_q [$];
  w_t                exp_mvp;

  always @(posedge clk) cyc++;

  function automatic logic [3*DW-1:0] mem_word(input logic [AW-1:0] a);
    return {12'h000, a, 12'h5A5, a, 12'hC3C, a};
  endfunction

  function automatic w_t flat(input logic signed [DW-1:0] m [4][4]);
    w_t f = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) f[(r*4+c)*DW +: DW] = m[r][c];
    return f;
  endfunction

  task automatic check(input string tag, input w_t obs, input w_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Synchronous memory model: data valid the cycle after the read enable.
  always @(posedge clk) begin
    if (o_mem_en) i_mem_data <= mem_word(o_mem_addr);
    else          i_mem_data <= 72'({$urandom(), $urandom(), $urandom()});
  end

  always @(negedge clk) begin
    rel_m = cyc - t0;
    if (rst) begin
      exp_addr_q.delete();
      exp_v_q.delete();
    end else begin
      if (o_mem_en) begin
        mem_cnt++;
        check("read_pending", w_t'(exp_addr_q.size() > 0), w_t'(1));
        if (exp_addr_q.size() > 0) check("read_addr", w_t'(o_mem_addr), w_t'(exp_addr_q.pop_front()));
      end
      if (o_mvp_dv) begin
        mvp_cnt++;
        mvp_rel = rel_m;
        check("mvp_matrix", flat(o_mvp_matrix), exp_mvp);
      end
      if (o_vertex_dv) begin
        check("vertex_pending", w_t'(exp_v_q.size() > 0), w_t'(1));
        if (exp_v_q.size() > 0) begin
          check("vertex", w_t'({o_vertex[0], o_vertex[1], o_vertex[2], o_vertex_last}), w_t'(exp_v_q[0]));
          if (i_ready) begin
            xfer_rel.push_back(rel_m);
            void'(exp_v_q.pop_front());
          end
        end
      end
      if (o_done) begin
        done_cnt++;
        done_rel = rel_m;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rand_matrix();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) i_mvp_matrix[r][c] = 24'($urandom());
  endtask

  // Queues the expected draw, pulses start, returns in cycle 1 (+1 time unit).
  task automatic start_draw(input logic [AW-1:0] base, input logic [AW-1:0] n);
    logic [AW-1:0]   a;
    logic [3*DW-1:0] w;
    rand_matrix();
    exp_mvp = flat(i_mvp_matrix);
    for (int i = 0; i < int'(n); i++) begin
      a = base + AW'(i);
      w = mem_word(a);
      exp_addr_q.push_back(a);
      exp_v_q.push_back({w, (i == int'(n) - 1)});
    end
    d0 = done_cnt; m0 = mvp_cnt; r0 = mem_cnt; x0 = xfer_rel.size();
    i_base_addr = base; i_vertex_count = n; i_start = 1'b1; t0 = cyc;
    step(1);
    i_start = 1'b0;
    i_base_addr = 12'($urandom());
    i_vertex_count = 12'($urandom());
    rand_matrix();
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (done_cnt == d0 && k < budget) begin
      step(1);
      k++;
    end
    check("done_within_budget", w_t'(done_cnt != d0), w_t'(1));
  endtask

  task automatic check_draw(input string tag, input int n, input int mvp_stall, input int pres_stall);
    check({tag, "_done_cnt"}, w_t'(done_cnt - d0), w_t'(1));
    check({tag, "_done_cyc"}, w_t'(done_rel), w_t'(n == 0 ? 1 : 2 + 3*n + mvp_stall + pres_stall));
    check({tag, "_mvp_cnt"}, w_t'(mvp_cnt - m0), w_t'(n == 0 ? 0 : 1));
    if (n != 0) check({tag, "_mvp_cyc"}, w_t'(mvp_rel), w_t'(1 + mvp_stall));
    check({tag, "_reads"}, w_t'(mem_cnt - r0), w_t'(n));
    check({tag, "_xfers"}, w_t'(xfer_rel.size() - x0), w_t'(n));
    check({tag, "_left"}, w_t'(exp_v_q.size() + exp_addr_q.size()), w_t'(0));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_mem_en"}, w_t'(o_mem_en), w_t'(0));
    check({tag, "_mem_addr"}, w_t'(o_mem_addr), w_t'(0));
    check({tag, "_mvp_dv"}, w_t'(o_mvp_dv), w_t'(0));
    check({tag, "_vertex_dv"}, w_t'(o_vertex_dv), w_t'(0));
    check({tag, "_vertex_last"}, w_t'(o_vertex_last), w_t'(0));
    check({tag, "_busy"}, w_t'(o_busy), w_t'(0));
    check({tag, "_done"}, w_t'(o_done), w_t'(0));
    check({tag, "_vertex"}, w_t'({o_vertex[0], o_vertex[1], o_vertex[2]}), w_t'(0));
    check({tag, "_matrix"}, flat(o_mvp_matrix), w_t'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired before the summary line");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; i_start = 1'b0; i_ready = 1'b1;
    i_base_addr = '0; i_vertex_count = '0;
    rand_matrix();

    // Reset held two cycles with random inputs.
    for (int k = 0; k < 2; k++) begin
      i_start = 1'($urandom()); i_ready = 1'($urandom());
      i_base_addr = 12'($urandom()); i_vertex_count = 12'($urandom());
      rand_matrix();
      step(1);
      check_zero("reset");
    end
    rst = 1'b0; i_start = 1'b0; i_ready = 1'b1;
    step(2);

    // Basic draw: base 0x010, N=3.
    start_draw(12'h010, 12'd3);
    check("basic_busy_c1", w_t'(o_busy), w_t'(1));
    wait_done(100);
    check("basic_busy_after", w_t'(o_busy), w_t'(0));
    check_draw("basic", 3, 0, 0);
    check("basic_xfer0", w_t'(xfer_rel[x0]), w_t'(4));
    check("basic_xfer1", w_t'(xfer_rel[x0+1]), w_t'(7));
    check("basic_xfer2", w_t'(xfer_rel[x0+2]), w_t'(10));
    step(2);

    // Backpressure: N=2, ready low for 5 cycles from the first PRESENT.
    start_draw(12'h123, 12'd2);
    step(3);
    check("bp_first_present", w_t'(o_vertex_dv), w_t'(1));
    i_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("bp_stall_mem_en", w_t'(o_mem_en), w_t'(0));
      step(1);
    end
    i_ready = 1'b1;
    wait_done(100);
    check_draw("bp", 2, 0, 5);
    check("bp_xfer0", w_t'(xfer_rel[x0]), w_t'(9));
    step(2);

    // Empty draw.
    start_draw(12'h040, 12'd0);
    check("empty_done_c1", w_t'(o_done), w_t'(1));
    check("empty_mvp_dv_c1", w_t'(o_mvp_dv), w_t'(0));
    step(1);
    check("empty_idle_c2", w_t'(o_busy), w_t'(0));
    check_draw("empty", 0, 0, 0);
    step(2);

    // Address wrap.
    start_draw(12'hFFE, 12'd4);
    wait_done(100);
    check_draw("wrap", 4, 0, 0);
    step(2);

    // Repeated start while busy, including in the DONE cycle.
    start_draw(12'h200, 12'd2);
    for (int c = 1; c <= 12; c++) begin
      if (c == 2 || c == 5 || c == 8) begin
        i_start = 1'b1;
        i_base_addr = 12'($urandom());
        i_vertex_count = 12'($urandom_range(1, 9));
      end else begin
        i_start = 1'b0;
      end
      step(1);
    end
    i_start = 1'b0;
    step(5);
    check_draw("restart", 2, 0, 0);

    // Reset during the second PRESENT of N=4.
    start_draw(12'h300, 12'd4);
    step(6);
    check("mreset_in_present", w_t'(o_vertex_dv), w_t'(1));
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check_zero("mreset");
    step(15);
    check("mreset_no_done", w_t'(done_cnt - d0), w_t'(0));
    check("mreset_idle", w_t'(o_busy), w_t'(0));

    // Fresh draw after reset, with two MVP stall cycles.
    i_ready = 1'b0;
    start_draw(12'h010, 12'd3);
    step(2);
    i_ready = 1'b1;
    wait_done(100);
    check_draw("fresh", 3, 2, 0);
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
